// File: rtl/ts_pkg.sv
// Shared timestamp widths and the truncated-to-full timestamp extension helper
// used on the receive side of the triggered timestamp generator.
package ts_pkg;
  localparam int TS1_BITS = 10;
  localparam int TS2_BITS = 7;
  localparam int TSOUT_W  = 40;
  localparam int TS2OUT_W = 32;

  // Returns {ext, borrow_from_zero}. snap_upper is the snapshot already shifted
  // down by n bits; n is the truncated width (TS1_BITS or TS2_BITS).
  function automatic logic [TSOUT_W:0] ts_extend(input logic [TSOUT_W-1:0]  snap_upper,
                                                 input logic [TS1_BITS-1:0] snap_lo,
                                                 input logic [TS1_BITS-1:0] trunc,
                                                 input int                  n);
    logic [TSOUT_W-1:0] ext;
    logic               bfz;
    bfz = 1'b0;
    if (trunc <= snap_lo)
      ext = (snap_upper << n) | TSOUT_W'(trunc);
    else if (snap_upper == '0) begin
      ext = TSOUT_W'(trunc);
      bfz = 1'b1;
    end else
      ext = ((snap_upper - TSOUT_W'(1)) << n) | TSOUT_W'(trunc);
    return {ext, bfz};
  endfunction
endpackage

// File: rtl/ts_extend_core.sv
// Combinational extension of one truncated chip timestamp against a live-counter
// snapshot, with optional latency check against MAXLAT.
module ts_extend_core
  import ts_pkg::*;
#(
  parameter int LO_W      = TS1_BITS,
  parameter int FULL_W    = TSOUT_W,
  parameter bit CHECK_LAT = 1'b1,
  parameter int MAXLAT    = 512
) (
  input  logic [FULL_W-1:0] snap,
  input  logic [LO_W-1:0]   trunc,
  output logic [FULL_W-1:0] ext,
  output logic              late,
  output logic              prerun
);
  logic [LO_W-1:0] d1;

  // modulo-2^LO_W distance between the snapshot and the chip timestamp
  assign d1     = snap[LO_W-1:0] - trunc;
  assign late   = CHECK_LAT && (int'(d1) > MAXLAT);
  assign ext    = FULL_W'(ts_extend(TSOUT_W'(snap >> LO_W), TS1_BITS'(snap[LO_W-1:0]),
                                    TS1_BITS'(trunc), LO_W) >> 1);
  assign prerun = 1'(ts_extend(TSOUT_W'(snap >> LO_W), TS1_BITS'(snap[LO_W-1:0]),
                               TS1_BITS'(trunc), LO_W));
endmodule

// File: rtl/hit_ts_extender.sv
// Two-stage hit pipeline: stage 1 snapshots the live TS counters on acceptance,
// stage 2 holds the extended timestamps and late/prerun flags for the readout FIFO.
module hit_ts_extender
  import ts_pkg::*;
#(
  parameter int PAYLOAD_W = 24,
  parameter int MAXLAT    = 512,
  parameter bit DROP_LATE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [TSOUT_W-1:0]   tsout,
  input  logic [TS2OUT_W-1:0]  ts2out,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TS1_BITS-1:0]  in_ts1,
  input  logic [TS2_BITS-1:0]  in_ts2,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TSOUT_W-1:0]   out_ts,
  output logic [TS2OUT_W-1:0]  out_ts2,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_late,
  output logic                 out_prerun,
  output logic [15:0]          hit_count,
  output logic [15:0]          late_count
);
  typedef struct packed {
    logic [TS1_BITS-1:0]  ts1;
    logic [TS2_BITS-1:0]  ts2;
    logic [PAYLOAD_W-1:0] payload;
    logic [TSOUT_W-1:0]   snap;
    logic [TS2OUT_W-1:0]  snap2;
  } s1_t;

  s1_t                s1;
  logic [2:1]         vld_pipe;
  logic               s1_advance, accept, s1_move, s2_load, flag;
  logic [TSOUT_W-1:0] ext1;
  logic [TS2OUT_W-1:0] ext2;
  logic               late1, late2, pre1, pre2;

  ts_extend_core #(.LO_W(TS1_BITS), .FULL_W(TSOUT_W), .CHECK_LAT(1'b1), .MAXLAT(MAXLAT)) u_ts1 (
    .snap(s1.snap), .trunc(s1.ts1), .ext(ext1), .late(late1), .prerun(pre1));

  ts_extend_core #(.LO_W(TS2_BITS), .FULL_W(TS2OUT_W), .CHECK_LAT(1'b0)) u_ts2 (
    .snap(s1.snap2), .trunc(s1.ts2), .ext(ext2), .late(late2), .prerun(pre2));

  assign s1_advance = !vld_pipe[2] || out_ready;
  assign in_ready   = !reset && enable && (!vld_pipe[1] || s1_advance);
  assign accept     = in_valid && in_ready;
  assign s1_move    = vld_pipe[1] && s1_advance;
  assign flag       = late1 || late2 || pre1 || pre2;
  // a dropped hit still leaves stage 1 so the stream keeps moving
  assign s2_load    = s1_move && !(DROP_LATE && flag);
  assign out_valid  = vld_pipe[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {vld_pipe, s1, out_ts, out_ts2, out_payload, out_late, out_prerun} <= '0;
      {hit_count, late_count} <= '0;
    end else if (!enable) begin
      {vld_pipe, s1, out_ts, out_ts2, out_payload, out_late, out_prerun} <= '0;
      {hit_count, late_count} <= '0;
    end else begin
      if (accept)
        s1 <= '{ts1: in_ts1, ts2: in_ts2, payload: in_payload, snap: tsout, snap2: ts2out};
      if (accept)          vld_pipe[1] <= 1'b1;
      else if (s1_advance) vld_pipe[1] <= 1'b0;
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        out_ts      <= ext1;
        out_ts2     <= ext2;
        out_payload <= s1.payload;
        out_late    <= late1;
        out_prerun  <= pre1 || pre2;
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
      if (accept && hit_count != '1)            hit_count  <= hit_count + 16'd1;
      if (s1_move && flag && late_count != '1)  late_count <= late_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_hit_ts_extender.sv
// Directed bench: two instances (forwarding and dropping flagged hits) share one
// stimulus; expected values are hand-computed in the vector table.
module tb_hit_ts_extender;
  logic        clock, reset, enable;
  logic [39:0] tsout;
  logic [31:0] ts2out;
  logic        in_valid, out_ready;
  logic [9:0]  in_ts1;
  logic [6:0]  in_ts2;
  logic [23:0] in_payload;

  logic        o0_in_ready, o0_out_valid, o0_late, o0_prerun;
  logic [39:0] o0_ts;
  logic [31:0] o0_ts2;
  logic [23:0] o0_payload;
  logic [15:0] o0_hits, o0_lates;
  logic        o1_in_ready, o1_out_valid, o1_late, o1_prerun;
  logic [39:0] o1_ts;
  logic [31:0] o1_ts2;
  logic [23:0] o1_payload;
  logic [15:0] o1_hits, o1_lates;

  int n_chk = 0, n_pass = 0;
  int exp_hits = 0, exp_late = 0;

  hit_ts_extender #(.PAYLOAD_W(24), .MAXLAT(512), .DROP_LATE(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .tsout(tsout), .ts2out(ts2out),
    .in_valid(in_valid), .in_ready(o0_in_ready), .in_ts1(in_ts1), .in_ts2(in_ts2),
    .in_payload(in_payload), .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_ts(o0_ts), .out_ts2(o0_ts2), .out_payload(o0_payload), .out_late(o0_late),
    .out_prerun(o0_prerun), .hit_count(o0_hits), .late_count(o0_lates));

  hit_ts_extender #(.PAYLOAD_W(24), .MAXLAT(512), .DROP_LATE(1'b1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .tsout(tsout), .ts2out(ts2out),
    .in_valid(in_valid), .in_ready(o1_in_ready), .in_ts1(in_ts1), .in_ts2(in_ts2),
    .in_payload(in_payload), .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_ts(o1_ts), .out_ts2(o1_ts2), .out_payload(o1_payload), .out_late(o1_late),
    .out_prerun(o1_prerun), .hit_count(o1_hits), .late_count(o1_lates));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] ts;
    logic [31:0] ts2;
    logic [9:0]  t1;
    logic [6:0]  t2;
    logic [39:0] e_ts;
    logic [31:0] e_ts2;
    logic        e_late;
    logic        e_pre;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clock);
    tsout = v.ts; ts2out = v.ts2; in_ts1 = v.t1; in_ts2 = v.t2;
    in_payload = 24'hA00000 + 24'(i); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk($sformatf("v%0d in_ready", i), o0_in_ready, 1);
    @(posedge clock);
    exp_hits++;
    if (v.e_late || v.e_pre) exp_late++;
    @(negedge clock);
    in_valid = 1'b0;
    chk($sformatf("v%0d valid early", i), o0_out_valid, 0);
    @(negedge clock);
    chk($sformatf("v%0d valid", i), o0_out_valid, 1);
    chk($sformatf("v%0d ts", i), o0_ts, v.e_ts);
    chk($sformatf("v%0d ts2", i), o0_ts2, v.e_ts2);
    chk($sformatf("v%0d late", i), o0_late, v.e_late);
    chk($sformatf("v%0d prerun", i), o0_prerun, v.e_pre);
    chk($sformatf("v%0d payload", i), o0_payload, 24'hA00000 + 24'(i));
    chk($sformatf("v%0d drop valid", i), o1_out_valid, !(v.e_late || v.e_pre));
    @(negedge clock);
    chk($sformatf("v%0d hit_count", i), o0_hits, exp_hits);
    chk($sformatf("v%0d late_count", i), o0_lates, exp_late);
    chk($sformatf("v%0d drop late_count", i), o1_lates, exp_late);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcvd, stalls;
    logic acc;
    vecs[0] = '{40'h1234,       32'h105,       10'h200, 7'h03, 40'h1200,       32'h103,       1'b0, 1'b0};
    vecs[1] = '{40'h2805,       32'h280,       10'h3F0, 7'h7F, 40'h27F0,       32'h27F,       1'b0, 1'b0};
    vecs[2] = '{40'h300,        32'h80,        10'h310, 7'h00, 40'h310,        32'h80,        1'b1, 1'b1};
    vecs[3] = '{40'hB00,        32'h80,        10'h0FF, 7'h00, 40'h8FF,        32'h80,        1'b1, 1'b0};
    vecs[4] = '{40'h1234,       32'h80,        10'h234, 7'h00, 40'h1234,       32'h80,        1'b0, 1'b0};
    vecs[5] = '{40'h400,        32'h80,        10'h3FF, 7'h00, 40'h3FF,        32'h80,        1'b0, 1'b0};
    vecs[6] = '{40'hB00,        32'h80,        10'h100, 7'h00, 40'h900,        32'h80,        1'b0, 1'b0};
    vecs[7] = '{40'h1234,       32'h05,        10'h234, 7'h10, 40'h1234,       32'h10,        1'b0, 1'b1};
    vecs[8] = '{40'hAB_CDEF_0123, 32'hFFFF_FF80, 10'h323, 7'h01, 40'hAB_CDEE_FF23, 32'hFFFF_FF01, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tsout = '0; ts2out = '0; in_ts1 = '0; in_ts2 = '0; in_payload = '0;
    repeat (2) @(negedge clock);
    chk("reset in_ready", o0_in_ready, 0);
    chk("reset out_valid", o0_out_valid, 0);
    chk("reset out_ts", o0_ts, 0);
    chk("reset flags", {o0_late, o0_prerun}, 0);
    chk("reset counts", {o0_hits, o0_lates}, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // back-to-back stream with a toggling consumer
    sent = 0; rcvd = 0; stalls = 0;
    for (int c = 0; c < 100 && rcvd < 8; c++) begin
      @(negedge clock);
      out_ready = (c % 2 == 0);
      in_valid  = (sent < 8);
      in_payload = 24'h5000 + 24'(sent);
      tsout = 40'h1234; ts2out = 32'h105; in_ts1 = 10'h200; in_ts2 = 7'h03;
      #1;
      if (in_valid && !o0_in_ready) begin
        stalls++;
        chk("stream stall only when full", {o0_out_valid, out_ready}, 2'b10);
      end
      if (o0_out_valid && out_ready) begin
        chk($sformatf("stream order %0d", rcvd), o0_payload, 24'h5000 + 24'(rcvd));
        rcvd++;
      end
      acc = in_valid && o0_in_ready;
      @(posedge clock);
      if (acc) sent++;
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream received", rcvd, 8);
    chk("stream stall seen", stalls != 0, 1);
    exp_hits += 8;
    @(negedge clock);
    chk("stream out_valid idle", o0_out_valid, 0);
    chk("stream hit_count", o0_hits, exp_hits);
    chk("drop hit_count", o1_hits, exp_hits);
    chk("drop late_count", o1_lates, 3);

    // fill both stages, then drop enable
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = 24'h77;
    @(posedge clock);
    @(negedge clock);
    in_payload = 24'h78;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("full out_valid", o0_out_valid, 1);
    chk("full in_ready", o0_in_ready, 0);
    chk("full payload", o0_payload, 24'h77);
    enable = 1'b0; in_valid = 1'b1;
    #1 chk("disabled in_ready", o0_in_ready, 0);
    @(negedge clock);
    chk("disable out_valid", o0_out_valid, 0);
    chk("disable counts", {o0_hits, o0_lates}, 0);
    chk("disable out_ts", o0_ts, 0);
    chk("disable in_ready", o0_in_ready, 0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("disable no emit", o0_out_valid, 0);
    enable = 1'b1; exp_hits = 0; exp_late = 0;
    run_vec(0);
    run_vec(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
